// File: rtl/vga_pkg.sv
// Shared VGA capture definitions: nominal 640x480 timing, capture state codes
// and the CRC-16-CCITT constants/step used by the frame signature.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first, non-reflected CRC-16-CCITT bit step.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator, one bit per cycle; clr loads the
// init value and takes priority over en.
module crc16_serial
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers h/v timing, locks, reports x/y, lit-pixel count and a
// frame signature. Define VGA_CAPTURE_CRC_EN to build the CRC signature.
module vga_capture
  import vga_pkg::*;
#(
  parameter logic        SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [10:0] H_MAX           = 11'd2047,
  parameter logic [9:0]  V_MAX           = 10'd1023
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_pixel,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        frame_done,
  output logic [19:0] lit_count,
  output logic [15:0] frame_sig,
  output logic [7:0]  err_count
);

  logic        hs_r, hs_p, vs_r, vs_p, px_r;
  logic        hs_edge, vs_edge;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [11:0] period;
  logic [1:0]  state, state_nxt;
  logic        h_seen;
  logic        err, done, latch_h, latch_v;
  logic [19:0] lit_cnt;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      hs_r <= 1'b0;
      hs_p <= 1'b0;
      vs_r <= 1'b0;
      vs_p <= 1'b0;
      px_r <= 1'b0;
    end else begin
      hs_r <= vga_hsync ^ SYNC_ACTIVE_LOW;
      vs_r <= vga_vsync ^ SYNC_ACTIVE_LOW;
      px_r <= vga_pixel;
      hs_p <= hs_r;
      vs_p <= vs_r;
    end
  end

  assign hs_edge = hs_r & ~hs_p;
  assign vs_edge = vs_r & ~vs_p;
  assign period  = {1'b0, h_cnt} + 12'd1;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_edge) begin
        h_cnt <= '0;
        if (v_cnt != V_MAX) v_cnt <= v_cnt + 10'd1;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + 11'd1;
      end
      if (vs_edge) v_cnt <= hs_edge ? 10'd1 : 10'd0;
    end
  end

  // Loss of signal outranks everything; then the hsync period check, so a
  // coincident vsync edge only counts when its line was well-formed.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    done      = 1'b0;
    latch_h   = 1'b0;
    latch_v   = 1'b0;
    if (state != SEARCH && h_cnt == H_MAX) begin
      err       = 1'b1;
      state_nxt = SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_edge) state_nxt = MEASURE;
        end
        MEASURE: begin
          if (hs_edge && h_seen && period != {1'b0, h_total}) begin
            err       = 1'b1;
            state_nxt = SEARCH;
          end else begin
            latch_h = hs_edge & ~h_seen;
            if (vs_edge && (h_seen || hs_edge)) begin
              latch_v   = 1'b1;
              state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (hs_edge && period != {1'b0, h_total}) begin
            err       = 1'b1;
            state_nxt = SEARCH;
          end else if (vs_edge) begin
            if (v_cnt != v_total) begin
              err       = 1'b1;
              state_nxt = SEARCH;
            end else begin
              done = 1'b1;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state      <= SEARCH;
      h_seen     <= 1'b0;
      h_total    <= '0;
      v_total    <= '0;
      err_count  <= '0;
      frame_done <= 1'b0;
      lit_cnt    <= '0;
      lit_count  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= done;
      if (state == SEARCH) h_seen <= 1'b0;
      else if (latch_h)    h_seen <= 1'b1;
      if (latch_h) h_total <= period[10:0];
      if (latch_v) v_total <= v_cnt;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (done) lit_count <= lit_cnt;
      if (vs_edge) lit_cnt <= {19'd0, px_r};
      else         lit_cnt <= lit_cnt + {19'd0, px_r};
    end
  end

  assign locked = (state == LOCKED);
  assign x      = locked ? h_cnt : '0;
  assign y      = locked ? v_cnt : '0;

`ifdef VGA_CAPTURE_CRC_EN
  logic        px_d;
  logic [15:0] crc;
  logic [15:0] sig_r;

  always_ff @(posedge clk) begin
    if (sys_rst) px_d <= 1'b0;
    else         px_d <= px_r;
  end

  // CRC runs one sample behind so its clear at the vsync edge does not drop
  // that edge's pixel; the closing frame's last sample is folded in here.
  crc16_serial u_crc (
    .clk     (clk),
    .sys_rst (sys_rst),
    .clr     (vs_edge),
    .en      (1'b1),
    .din     (px_d),
    .crc     (crc)
  );

  always_ff @(posedge clk) begin
    if (sys_rst)   sig_r <= '0;
    else if (done) sig_r <= crc16_step(crc, px_d);
  end

  assign frame_sig = sig_r;
`else
  assign frame_sig = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a scaled 64x20 raster with random pixels.
module tb_vga_capture;

  localparam int HT = 64, HS = 8, VT = 20, VS = 2;

  logic        clk = 1'b0;
  logic        sys_rst, vga_hsync, vga_vsync, vga_pixel;
  logic        locked, frame_done;
  logic [10:0] h_total, x;
  logic [9:0]  v_total, y;
  logic [19:0] lit_count;
  logic [15:0] frame_sig;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  vga_capture dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_pixel  (vga_pixel),
    .locked     (locked),
    .h_total    (h_total),
    .v_total    (v_total),
    .x          (x),
    .y          (y),
    .frame_done (frame_done),
    .lit_count  (lit_count),
    .frame_sig  (frame_sig),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic [19:0] lit;
    logic [15:0] sig;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          m_lit;
  logic [15:0] m_crc;
  bit          m_vs_prev;
  int          clean_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic [16:0] t;
    t = {c, 1'b0};
    if (c[15] ^ b) t[15:0] = t[15:0] ^ 16'h1021;
    return t[15:0];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 0);
    check({tag, "_totals"}, {11'd0, h_total, v_total}, 0);
    check({tag, "_xy"}, {11'd0, x, y}, 0);
    check({tag, "_done_err"}, {23'd0, frame_done, err_count}, 0);
    check({tag, "_lit"}, {12'd0, lit_count}, 0);
    check({tag, "_sig"}, {16'd0, frame_sig}, 0);
  endtask

  // chk: 0 none, 1 x/y at line 5 col 30, 2 all-zero after reset
  task automatic drive(input bit hs_a, input bit vs_a, input bit px, input bit rst, input int chk);
    @(negedge clk);
    if (chk == 1) begin
      check("x_line5", {21'd0, x}, 28);
      check("y_line5", {22'd0, y}, 5);
    end else if (chk == 2) begin
      check_zero("midrst");
    end
    sys_rst   = rst;
    vga_hsync = ~hs_a;
    vga_vsync = ~vs_a;
    vga_pixel = px;
    if (vs_a && !m_vs_prev) begin
      if (clean_vs >= 2) begin
`ifdef VGA_CAPTURE_CRC_EN
        q.push_back({m_lit[19:0], m_crc});
`else
        q.push_back({m_lit[19:0], 16'h0000});
`endif
      end
      clean_vs++;
      m_lit = 0;
      m_crc = 16'hFFFF;
    end
    m_vs_prev = vs_a;
    m_lit += int'(px);
    m_crc = crc_bit(m_crc, px);
  endtask

  task automatic drive_frame(input int vs_off, input int short_line, input bit chk_xy, input bit do_rst);
    int dens;
    dens = $urandom_range(1, 99);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      if (l == short_line) clean_vs = 0;
      for (int c = 0; c < len; c++) begin
        bit hs_a, vs_a, px, rst;
        int chk;
        hs_a = (c < HS);
        vs_a = (l > 0 && l < VS) || (l == 0 && c >= vs_off) || (l == VS && c < vs_off);
        px   = (l >= 4 && l < 18 && c >= 16 && c < 56) ? ($urandom_range(0, 99) < dens) : 1'b0;
        rst  = do_rst && l == 8 && c == 30;
        chk  = (chk_xy && l == 5 && c == 30) ? 1 : ((do_rst && l == 8 && c == 31) ? 2 : 0);
        if (rst) clean_vs = 0;
        drive(hs_a, vs_a, px, rst, chk);
      end
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL frame_done: got unexpected pulse, expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("lit_count", {12'd0, lit_count}, {12'd0, e.lit});
        check("frame_sig", {16'd0, frame_sig}, {16'd0, e.sig});
      end
    end
  end

  initial begin
    sys_rst   = 1'b1;
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    vga_pixel = 1'b0;
    m_lit = 0; m_crc = 16'hFFFF; m_vs_prev = 1'b0; clean_vs = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    sys_rst = 1'b0;

    drive_frame(10, -1, 0, 0);
    check("locked_after_1st_vs", {31'd0, locked}, 0);
    drive_frame(10, -1, 0, 0);
    check("locked_after_2nd_vs", {31'd0, locked}, 1);
    check("h_total", {21'd0, h_total}, HT);
    check("v_total", {22'd0, v_total}, VT);
    drive_frame(10, -1, 1, 0);
    drive_frame(10, -1, 0, 0);
    drive_frame(10, -1, 0, 0);

    drive_frame(10, 7, 0, 0);
    check("locked_after_short", {31'd0, locked}, 0);
    check("err_after_short", {24'd0, err_count}, 1);
    drive_frame(10, -1, 0, 0);
    check("relock_1st_vs", {31'd0, locked}, 0);
    drive_frame(10, -1, 0, 0);
    check("relock_2nd_vs", {31'd0, locked}, 1);
    drive_frame(10, -1, 0, 0);
    drive_frame(10, -1, 0, 0);

    drive_frame(10, -1, 0, 0);
    clean_vs = 0;
    for (int i = 0; i < 3000; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
      if (i == 1900) check("hold_still_locked", {31'd0, locked}, 1);
      if (i == 2100) check("hold_lost_lock", {31'd0, locked}, 0);
    end
    check("err_after_hold", {24'd0, err_count}, 2);
    drive_frame(10, -1, 0, 0);
    drive_frame(10, -1, 0, 0);
    check("relock_after_hold", {31'd0, locked}, 1);
    drive_frame(10, -1, 0, 0);

    drive_frame(10, -1, 0, 1);
    drive_frame(0, -1, 0, 0);
    check("coinc_1st_vs", {31'd0, locked}, 0);
    drive_frame(0, -1, 0, 0);
    check("coinc_locked", {31'd0, locked}, 1);
    check("coinc_v_total", {22'd0, v_total}, VT);
    check("coinc_h_total", {21'd0, h_total}, HT);
    for (int f = 0; f < 5; f++) drive_frame(0, -1, 0, 0);
    check("coinc_still_locked", {31'd0, locked}, 1);
    check("coinc_err_count", {24'd0, err_count}, 0);

    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
